// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache answering fetch requests, refilling lines from memory on a miss.
// Optional ICACHE_PERF_CNT_EN adds 32-bit hit/miss counters.
module icache_responder #(
    parameter int ADR_WIDTH    = 32,
    parameter int RETURN_BYTES = 4,
    parameter int LINE_BYTES   = 16,
    parameter int LINES        = 64,
    parameter int MEM_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADR_WIDTH-1:0]      address,
    input  logic                      req_valid,
    input  logic                      flush,
    output logic [RETURN_BYTES*8-1:0] cache_data_out,
    output logic [ADR_WIDTH-1:0]      cache_adr_out,
    output logic                      data_valid,
    output logic                      cache_miss,
    output logic                      busy,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADR_WIDTH-1:0]      mem_req_adr,
    input  logic [MEM_BYTES*8-1:0]    mem_rdata,
    input  logic                      mem_rvalid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses
`endif
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADR_WIDTH - OFF_W - IDX_W;
    localparam int BEATS  = LINE_BYTES / MEM_BYTES;
    localparam int CNT_W  = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WORD_W = RETURN_BYTES * 8;
    localparam int BEAT_W = MEM_BYTES * 8;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [LINE_W-1:0]  lines [LINES];
    logic [ADR_WIDTH-1:0] lat_adr;
    logic [LINE_W-1:0]  line_buf;
    logic [LINE_W-1:0]  fill_line;
    logic [CNT_W-1:0]   bcnt;
    logic               flush_pend;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   lat_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   lat_tag;
    logic               hit;
    logic               last_beat;

    function automatic logic [WORD_W-1:0] pick(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] off);
        return WORD_W'(l >> {off & ~OFF_W'(RETURN_BYTES - 1), 3'b000});
    endfunction

    assign req_idx   = address[OFF_W +: IDX_W];
    assign req_tag   = address[ADR_WIDTH-1 -: TAG_W];
    assign lat_idx   = lat_adr[OFF_W +: IDX_W];
    assign lat_tag   = lat_adr[ADR_WIDTH-1 -: TAG_W];
    assign hit       = valid[req_idx] && tags[req_idx] == req_tag;
    assign last_beat = state == FILL && mem_rvalid && bcnt == CNT_W'(BEATS - 1);

    // line buffer with the current beat merged in, so the last beat can be written and answered in one edge
    always_comb begin
        fill_line = line_buf;
        fill_line[bcnt*BEAT_W +: BEAT_W] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst && last_beat) begin
            tags[lat_idx]  <= lat_tag;
            lines[lat_idx] <= fill_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            valid          <= '0;
            data_valid     <= 1'b0;
            cache_miss     <= 1'b0;
            busy           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_adr    <= '0;
            cache_data_out <= '0;
            cache_adr_out  <= '0;
            lat_adr        <= '0;
            line_buf       <= '0;
            bcnt           <= '0;
            flush_pend     <= 1'b0;
`ifdef ICACHE_PERF_CNT_EN
            perf_hits      <= '0;
            perf_misses    <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            cache_miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (req_valid && hit) begin
                        data_valid     <= 1'b1;
                        cache_data_out <= pick(lines[req_idx], address[OFF_W-1:0]);
                        cache_adr_out  <= address;
`ifdef ICACHE_PERF_CNT_EN
                        perf_hits      <= perf_hits + 32'd1;
`endif
                    end else if (req_valid) begin
                        cache_miss    <= 1'b1;
                        lat_adr       <= address;
                        mem_req_valid <= 1'b1;
                        mem_req_adr   <= {address[ADR_WIDTH-1:OFF_W], OFF_W'(0)};
                        busy          <= 1'b1;
                        state         <= REQ;
`ifdef ICACHE_PERF_CNT_EN
                        perf_misses   <= perf_misses + 32'd1;
`endif
                    end
                end
                REQ: begin
                    flush_pend <= flush_pend | flush;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        bcnt          <= '0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    flush_pend <= flush_pend | flush;
                    if (mem_rvalid) begin
                        line_buf <= fill_line;
                        bcnt     <= bcnt + 1'b1;
                    end
                    if (last_beat) begin
                        valid[lat_idx] <= !(flush_pend || flush);
                        data_valid     <= 1'b1;
                        cache_data_out <= pick(fill_line, lat_adr[OFF_W-1:0]);
                        cache_adr_out  <= lat_adr;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (flush_pend || flush) valid <= '0;
                    flush_pend <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache side of the fetch/decode cache interface.
- Services fetch address requests from a direct-mapped line store.
- Returns the instruction word and its address to decode.
- On a miss, runs a line refill from the memory side, then completes the original request.

Parameters:
ADR_WIDTH, 32, address width.
RETURN_BYTES, 4, bytes returned per request (one instruction word).
LINE_BYTES, 16, bytes per cache line; power of two, >= RETURN_BYTES.
LINES, 64, number of lines; power of two.
MEM_BYTES, 4, bytes per memory read beat; LINE_BYTES/MEM_BYTES beats per refill.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
address  in  ADR_WIDTH  fetch request address
req_valid  in  1  fetch request strobe
flush  in  1  invalidate all lines
cache_data_out  out  RETURN_BYTES*8  returned instruction word
cache_adr_out  out  ADR_WIDTH  address of returned word
data_valid  out  1  cache_data_out/cache_adr_out valid this cycle
cache_miss  out  1  one-cycle pulse: accepted request missed
busy  out  1  state != IDLE; requests ignored
mem_req_valid  out  1  refill request
mem_req_ready  in  1  memory accepts refill request
mem_req_adr  out  ADR_WIDTH  line-aligned refill address
mem_rdata  in  MEM_BYTES*8  refill beat data
mem_rvalid  in  1  refill beat valid

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Address split:
  - offset = log2(LINE_BYTES) bits (4).
  - index = log2(LINES) bits (6).
  - tag = the remaining bits (22).
  - Word select = offset[log2(LINE_BYTES)-1 : log2(RETURN_BYTES)].
  - address low log2(RETURN_BYTES) bits are ignored.
- Storage: per line one valid bit, one tag and LINE_BYTES of data. Reads are registered (1-cycle).
- Reset values:
  - All outputs 0; state IDLE; all valid bits 0.
  - A reset during a refill aborts it. mem_rvalid beats arriving afterwards are ignored because the state is IDLE.
- FSM states:
  - IDLE:
    - A request is accepted when req_valid=1 and flush=0.
    - Hit (valid and tag match): in cycle N+1, data_valid=1, cache_data_out=selected word, cache_adr_out=address captured at N. State stays IDLE, giving back-to-back 1-request/cycle throughput.
    - Miss: in cycle N+1, cache_miss=1 and data_valid=0. The address is latched and the state moves to REQ.
  - REQ:
    - mem_req_valid=1, mem_req_adr = latched address with offset bits zeroed.
    - mem_req_valid and mem_req_adr are held stable until mem_req_ready; then go to FILL.
  - FILL:
    - Each mem_rvalid writes mem_rdata into the line buffer at the next beat slot, ascending from slot 0.
    - A 2-bit (log2 beats) counter tracks beats.
    - On the last beat: write data, tag and valid into the indexed line, then go to RESP.
    - mem_rvalid is legal in the same cycle as the mem_req_ready handshake completes only if memory supports it. The block captures beats only while in FILL.
  - RESP: one cycle with data_valid=1, cache_data_out = requested word, cache_adr_out = latched miss address. Then go to IDLE.
- busy=1 in REQ/FILL/RESP. req_valid is ignored in these states; fetch re-issues the request.
- Flush:
  - In IDLE, flush clears all valid bits at the clock edge and wins over a same-cycle req_valid. That request is dropped with no response.
  - During REQ/FILL/RESP, flush is recorded as pending. The refill completes and the original request is still answered in RESP, but the refilled line is written with valid=0. All valid bits are cleared on entry to IDLE.
- Replacement: direct-mapped; a refill overwrites its indexed line unconditionally.
- Outputs data_valid and cache_miss are never 1 in the same cycle.

Optional Feature:
ICACHE_PERF_CNT_EN:
- Defined: adds outputs perf_hits and perf_misses, each 32 bits.
  - Incremented on each hit/miss response; wrap at 2^32.
  - Cleared by rst, not by flush.
- Not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req 0x0000_1004 (cold) -> cycle+1 cache_miss=1. mem_req_adr=0x0000_1000. After 4 beats 0x11,0x22,0x33,0x44, RESP gives data_valid=1, cache_data_out=0x22, cache_adr_out=0x0000_1004. busy drops the next cycle.
- After the above, requests 0x1000,0x1008,0x100C on consecutive cycles -> data_valid on 3 consecutive cycles with 0x11,0x33,0x44; no mem_req_valid.
- Conflict: req 0x0000_2004 (same index, different tag) -> miss and refill. Then 0x1004 misses again, showing the line was replaced.
- Flush asserted in FILL beat 2 -> RESP still returns the correct word. A subsequent req to the same address misses.
- Backpressure: mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_adr stable throughout; req_valid pulses during busy produce no responses.
- rst asserted mid-FILL after 2 beats -> outputs 0, state IDLE. Stray mem_rvalid is ignored, and re-requesting the address misses.
